isram_axi_rd_slave: RTL and testbench

- AXI4-style read-only responder that models the instruction SRAM on the fetch path; it is the slave end of the isram AR/R channels that the IFU drives.
- Accepts one read request at a time and returns 1..256 beats with configurable first-beat latency.
- Responds SLVERR/DECERR on illegal or out-of-range requests.
- Backing store is an internal word array with a backdoor load port for program preload in simulation and test.

---
 rtl/isram_axi_rd_slave.sv | 191 +++++++++++++++++++
 tb/tb_isram_axi_rd_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isram_axi_rd_slave.sv
// isram_axi_rd_slave
//   Read-only AXI4-style responder standing in for the instruction SRAM on
//   the fetch path. It takes one AR request at a time and returns arlen+1
//   beats, with a programmable delay before the first beat. Illegal
//   requests get SLVERR and unmapped addresses get DECERR. A backdoor port
//   preloads the word array.
//
// Ports
//   clock, reset             clock and synchronous active-high reset
//   arvalid/arready          AR handshake
//   araddr/arlen/arid        first-beat byte address, beats-1, transaction id
//   arsize/arburst           beat size (only 3'b010 is legal), burst type
//   rvalid/rready            R handshake
//   rdata                    read word replicated in both halves {word, word}
//   rresp/rlast/rid          beat response, final-beat flag, echoed id
//   load_en/addr/data        backdoor word write (same address map as araddr)
module isram_axi_rd_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [DATA_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [3:0]              arid,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [2*DATA_WIDTH-1:0] rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [3:0]              rid,
    input  logic                    load_en,
    input  logic [DATA_WIDTH-1:0]   load_addr,
    input  logic [DATA_WIDTH-1:0]   load_data
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, WAIT_LAT, DATA} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t                state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rword_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [3:0]            rid_q;
    logic [3:0]            lat_q;
    logic [7:0]            beat_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [3:0]            id_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;

    // True when addr maps onto a word of the array.
    function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] word_off;
        word_off = (addr - BASE_ADDR) >> 2;
        return (addr >= BASE_ADDR) && (word_off < DATA_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] word_off;
        word_off = (addr - BASE_ADDR) >> 2;
        return word_off[IDX_W-1:0];
    endfunction

    // Address of the beat being latched: the start address while leaving
    // WAIT_LAT, the following beat while advancing in DATA.
    logic [DATA_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] beat_addr;
    logic [1:0]            beat_resp;
    logic [IDX_W-1:0]      beat_idx;

    always_comb begin
        next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + DATA_WIDTH'(4);
        beat_addr = (state_q == DATA) ? next_addr : addr_q;
        beat_idx  = word_idx(beat_addr);
        // Protocol violations take precedence over address decode.
        if (size_q != 3'b010 || burst_q[1] || beat_addr[1:0] != 2'b00) begin
            beat_resp = RESP_SLVERR;
        end else if (!in_range(beat_addr)) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_resp = RESP_OKAY;
        end
    end

    // Backdoor load; not gated by reset or FSM state.
    logic load_ok;
    assign load_ok = load_en && (load_addr[1:0] == 2'b00) && in_range(load_addr);

    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[word_idx(load_addr)] <= load_data;
        end
    end

    // Request/response FSM. The array is read inside this block so a beat
    // latched on the same edge as a backdoor write sees the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rword_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            lat_q     <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            size_q    <= '0;
            burst_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arvalid && arready_q) begin
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        id_q      <= arid;
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        arready_q <= 1'b0;
                        lat_q     <= 4'(RD_LATENCY - 1);
                        state_q   <= WAIT_LAT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                WAIT_LAT: begin
                    if (lat_q == 4'd0) begin
                        rvalid_q <= 1'b1;
                        rword_q  <= (beat_resp == RESP_OKAY) ? mem[beat_idx] : '0;
                        rresp_q  <= beat_resp;
                        rlast_q  <= (len_q == 8'd0);
                        rid_q    <= id_q;
                        beat_q   <= 8'd0;
                        state_q  <= DATA;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            // Next beat loads on the accepting edge: no bubble.
                            addr_q  <= next_addr;
                            beat_q  <= beat_q + 8'd1;
                            rword_q <= (beat_resp == RESP_OKAY) ? mem[beat_idx] : '0;
                            rresp_q <= beat_resp;
                            rlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata_rep
        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rword_q;
    end

endmodule

// File: tb/tb_isram_axi_rd_slave.sv
module tb_isram_axi_rd_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    always #5 clock = ~clock;

    isram_axi_rd_slave dut (
        .clock     (clock),
        .reset     (reset),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arid      (arid),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    int          got_n;

    localparam logic [31:0] W0 = 32'h0000_0413;
    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;
    localparam logic [31:0] WD = 32'hDDDD_0004;
    localparam logic [31:0] WE = 32'h1234_5678;

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clock); #1;
        load_en   = 1'b0;
    endtask

    // Presents one AR request and returns just after its handshake edge.
    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        n = 0;
        arvalid = 1'b1;
        araddr  = a;
        arlen   = len;
        arid    = id;
        arsize  = size;
        arburst = burst;
        while (arready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            tests_failed++;
            $display("FAIL ar_timeout: arready=%b required 1", arready);
        end
        @(posedge clock); #1;
        arvalid = 1'b0;
    endtask

    // Accepts n beats; beat stall_beat is held with rready low for stall_cycles cycles.
    task automatic recv_beats(input int n, input int stall_beat, input int stall_cycles);
        int cycles;
        int stalled;
        cycles  = 0;
        stalled = 0;
        got_n   = 0;
        rready  = 1'b1;
        while (got_n < n && cycles < 200) begin
            if (rvalid === 1'b1) begin
                if (got_n == stall_beat && stalled < stall_cycles) begin
                    if (stalled != 0) begin
                        tests_run++;
                        if (rdata !== got_data[got_n] || rlast !== got_last[got_n]) begin
                            tests_failed++;
                            $display("FAIL stall_hold: rdata=%h rlast=%b required %h %b",
                                     rdata, rlast, got_data[got_n], got_last[got_n]);
                        end
                    end
                    got_data[got_n] = rdata;
                    got_last[got_n] = rlast;
                    rready = 1'b0;
                    stalled++;
                end else begin
                    got_data[got_n] = rdata;
                    got_resp[got_n] = rresp;
                    got_last[got_n] = rlast;
                    got_id[got_n]   = rid;
                    got_n++;
                    rready = 1'b1;
                end
            end else if (stalled != 0 && stalled < stall_cycles) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stall_valid: rvalid=%b required 1", rvalid);
            end
            @(posedge clock); #1;
            cycles++;
        end
        rready = 1'b1;
        tests_run++;
        if (got_n != n) begin
            tests_failed++;
            $display("FAIL beat_count: got %0d beats required %0d", got_n, n);
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arid    = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        @(posedge clock); #1;
        load_word(32'h8000_0000, W0);
        tests_run++;
        if (arready !== 1'b0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: arready=%b rvalid=%b required 0 0", arready, rvalid);
        end
        tests_run++;
        if (rdata !== 64'd0 || rresp !== 2'b00 || rlast !== 1'b0 || rid !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_r: rdata=%h rresp=%b rlast=%b rid=%h required 0", rdata, rresp, rlast, rid);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single;
        do_ar(32'h8000_0000, 8'd0, 4'd3, 3'b010, 2'b01);
        tests_run++;
        if (rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: rvalid=%b required 0", rvalid);
        end
        @(posedge clock); #1;
        tests_run++;
        if (rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_latency: rvalid=%b required 1", rvalid);
        end
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== 64'h0000_0413_0000_0413 || got_resp[0] !== 2'b00 ||
            got_last[0] !== 1'b1 || got_id[0] !== 4'd3) begin
            tests_failed++;
            $display("FAIL single_beat: data=%h resp=%b last=%b id=%h required 0000041300000413 00 1 3",
                     got_data[0], got_resp[0], got_last[0], got_id[0]);
        end
        tests_run++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        $display("[TB] single read data=%h", got_data[0]);
    endtask

    task automatic test_incr_stall;
        logic [31:0] exp_w [4];
        logic [63:0] exp_d;
        exp_w[0] = WA; exp_w[1] = WB; exp_w[2] = WC; exp_w[3] = WD;
        for (int i = 0; i < 4; i++) load_word(32'h8000_0008 + 32'(4 * i), exp_w[i]);
        do_ar(32'h8000_0008, 8'd3, 4'd5, 3'b010, 2'b01);
        recv_beats(4, 1, 3);
        for (int i = 0; i < 4; i++) begin
            exp_d = {exp_w[i], exp_w[i]};
            tests_run++;
            if (got_data[i] !== exp_d || got_resp[i] !== 2'b00 || got_last[i] !== (i == 3) || got_id[i] !== 4'd5) begin
                tests_failed++;
                $display("FAIL incr_beat%0d: data=%h resp=%b last=%b id=%h required %h 00 %b 5",
                         i, got_data[i], got_resp[i], got_last[i], got_id[i], exp_d, (i == 3));
            end
        end
        $display("[TB] incr burst with stall, %0d beats", got_n);
    endtask

    task automatic test_fixed;
        logic [63:0] exp_d;
        exp_d = {WC, WC};
        do_ar(32'h8000_0010, 8'd2, 4'd7, 3'b010, 2'b00);
        recv_beats(3, -1, 0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_data[i] !== exp_d || got_resp[i] !== 2'b00 || got_last[i] !== (i == 2) || got_id[i] !== 4'd7) begin
                tests_failed++;
                $display("FAIL fixed_beat%0d: data=%h resp=%b last=%b id=%h required %h 00 %b 7",
                         i, got_data[i], got_resp[i], got_last[i], got_id[i], exp_d, (i == 2));
            end
        end
        $display("[TB] fixed burst, %0d beats", got_n);
    endtask

    task automatic test_illegal_burst;
        do_ar(32'h8000_0000, 8'd2, 4'd9, 3'b010, 2'b10);
        recv_beats(3, -1, 0);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_data[i] !== 64'd0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 2) || got_id[i] !== 4'd9) begin
                tests_failed++;
                $display("FAIL illegal_beat%0d: data=%h resp=%b last=%b id=%h required 0 10 %b 9",
                         i, got_data[i], got_resp[i], got_last[i], got_id[i], (i == 2));
            end
        end
        $display("[TB] illegal burst type, %0d beats", got_n);
    endtask

    task automatic test_errors;
        do_ar(32'h7FFF_FFFC, 8'd0, 4'd1, 3'b010, 2'b01);
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== 64'd0 || got_resp[0] !== 2'b11 || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL decerr_low: data=%h resp=%b last=%b required 0 11 1", got_data[0], got_resp[0], got_last[0]);
        end
        do_ar(32'h8000_0002, 8'd0, 4'd2, 3'b010, 2'b01);
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== 64'd0 || got_resp[0] !== 2'b10 || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL slverr_align: data=%h resp=%b last=%b required 0 10 1", got_data[0], got_resp[0], got_last[0]);
        end
        do_ar(32'h8000_0000, 8'd0, 4'd4, 3'b011, 2'b01);
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== 64'd0 || got_resp[0] !== 2'b10) begin
            tests_failed++;
            $display("FAIL slverr_size: data=%h resp=%b required 0 10", got_data[0], got_resp[0]);
        end
        $display("[TB] error responses checked");
    endtask

    task automatic test_cross_end;
        load_word(32'h8000_3FFC, WE);
        do_ar(32'h8000_3FFC, 8'd1, 4'd6, 3'b010, 2'b01);
        recv_beats(2, -1, 0);
        tests_run++;
        if (got_data[0] !== {WE, WE} || got_resp[0] !== 2'b00 || got_last[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL cross_beat0: data=%h resp=%b last=%b required %h 00 0", got_data[0], got_resp[0], got_last[0], {WE, WE});
        end
        tests_run++;
        if (got_data[1] !== 64'd0 || got_resp[1] !== 2'b11 || got_last[1] !== 1'b1 || got_id[1] !== 4'd6) begin
            tests_failed++;
            $display("FAIL cross_beat1: data=%h resp=%b last=%b id=%h required 0 11 1 6",
                     got_data[1], got_resp[1], got_last[1], got_id[1]);
        end
        $display("[TB] burst across array end");
    endtask

    task automatic test_reset_mid_burst;
        do_ar(32'h8000_0008, 8'd7, 4'd8, 3'b010, 2'b01);
        recv_beats(2, -1, 0);
        tests_run++;
        if (rvalid !== 1'b1 || rdata !== {WC, WC}) begin
            tests_failed++;
            $display("FAIL mid_beat2: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, {WC, WC});
        end
        reset  = 1'b1;
        rready = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: rvalid=%b arready=%b required 0 0", rvalid, arready);
        end
        @(posedge clock); #1;
        reset  = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            tests_run++;
            if (rvalid !== 1'b0 || arready !== 1'b1) begin
                tests_failed++;
                $display("FAIL mid_idle%0d: rvalid=%b arready=%b required 0 1", i, rvalid, arready);
            end
        end
        do_ar(32'h8000_0000, 8'd0, 4'd10, 3'b010, 2'b01);
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== {W0, W0} || got_resp[0] !== 2'b00 || got_id[0] !== 4'd10) begin
            tests_failed++;
            $display("FAIL mid_after0: data=%h resp=%b id=%h required %h 00 a", got_data[0], got_resp[0], got_id[0], {W0, W0});
        end
        do_ar(32'h8000_000C, 8'd0, 4'd11, 3'b010, 2'b01);
        recv_beats(1, -1, 0);
        tests_run++;
        if (got_data[0] !== {WB, WB} || got_resp[0] !== 2'b00 || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_after1: data=%h resp=%b last=%b required %h 00 1", got_data[0], got_resp[0], got_last[0], {WB, WB});
        end
        $display("[TB] reset mid-burst recovered");
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_stall();
        test_fixed();
        test_illegal_burst();
        test_errors();
        test_cross_end();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
